addsub_share_ctrl: RTL and testbench

Round-robin controller that shares one 64-bit two's-complement add/subtract datapath between two requesters (execute-stage ALU and address/stack-pointer update path) in the Y86 SEQ design. Latches the granted requester's operands and opcode, computes a+b or a−b (a + ~b + 1), registers result and condition flags, and returns a one-cycle completion pulse to the owner. Back-to-back operations are supported without an idle gap.

---
 rtl/addsub_share_ctrl.sv | 170 +++++++++++++++++
 tb/tb_addsub_share_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/addsub_share_ctrl.sv
// addsub_share_ctrl: round-robin sharing of one add/sub datapath between two
// requesters. Optional zero/sign flags are enabled by `define ADDSUB_SHARE_CC_EN.
// Ports: clk, rst_n (async, active low); req0/1, op0/1 (0 add, 1 sub),
//   a0/b0, a1/b1 operands; gnt0/1 grant pulses; done0/1 completion pulses;
//   result, overflow, zf, sf of the last completed op; busy in EXEC/RESP.
module addsub_share_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             op0,
    input  logic             op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zf,
    output logic             sf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             own_q, own_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             ovf_q, ovf_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             busy_q, busy_d;

    logic             any_req;
    logic             pick1;
    logic             take;
    logic [WIDTH-1:0] b_x;
    logic [WIDTH-1:0] sum;
    logic             ovf;

    // Subtraction is a + ~b + 1; the carry-in is the opcode itself.
    assign b_x = op_q ? ~b_q : b_q;
    assign sum = a_q + b_x + {{(WIDTH-1){1'b0}}, op_q};
    // Signed overflow: effective operands agree in sign, result does not.
    assign ovf = (a_q[WIDTH-1] == b_x[WIDTH-1]) &&
                 (sum[WIDTH-1] != a_q[WIDTH-1]);

    assign any_req = req0 | req1;
    // On a tie, the requester that did not own the datapath last wins.
    assign pick1   = req1 & (~req0 | ~last_q);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        own_d   = own_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        take    = 1'b0;
        unique case (state_q)
            IDLE: take = any_req;
            EXEC: begin
                state_d = RESP;
                res_d   = sum;
                ovf_d   = ovf;
                done0_d = ~own_q;
                done1_d = own_q;
            end
            RESP: begin
                take    = any_req;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            state_d = EXEC;
            own_d   = pick1;
            last_d  = pick1;
            op_d    = pick1 ? op1 : op0;
            a_d     = pick1 ? a1 : a0;
            b_d     = pick1 ? b1 : b0;
            gnt0_d  = ~pick1;
            gnt1_d  = pick1;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            own_q   <= 1'b0;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            own_q   <= own_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            busy_q  <= busy_d;
        end
    end

`ifdef ADDSUB_SHARE_CC_EN
    logic zf_q, sf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf_q <= 1'b0;
            sf_q <= 1'b0;
        end else if (state_q == EXEC) begin
            zf_q <= (sum == '0);
            sf_q <= sum[WIDTH-1];
        end
    end

    assign zf = zf_q;
    assign sf = sf_q;
`else
    assign zf = 1'b0;
    assign sf = 1'b0;
`endif

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign result   = res_q;
    assign overflow = ovf_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// tb_addsub_share_ctrl: directed vector bench for addsub_share_ctrl.
// Drives and samples on the falling edge; flags follow ADDSUB_SHARE_CC_EN.
module tb_addsub_share_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        op0 = 1'b0, op1 = 1'b0;
    logic [63:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        gnt0, gnt1, done0, done1;
    logic [63:0] result;
    logic        overflow, zf, sf, busy;

    int n_chk = 0;
    int n_fail = 0;

    addsub_share_ctrl #(.WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .overflow(overflow), .zf(zf), .sf(sf),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          who;
        logic        op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
        logic        ovf;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic exp_zf(input logic [63:0] r);
`ifdef ADDSUB_SHARE_CC_EN
        return (r == 64'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_sf(input logic [63:0] r);
`ifdef ADDSUB_SHARE_CC_EN
        return r[63];
`else
        return 1'b0;
`endif
    endfunction

    // No cycle may carry two grants, two dones, or gnt+done for one owner.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("excl gnt", {63'd0, gnt0 & gnt1}, 64'd0);
            chk("excl done", {63'd0, done0 & done1}, 64'd0);
            chk("excl gd", {63'd0, (gnt0 & done0) | (gnt1 & done1)}, 64'd0);
        end
    end

    task automatic chk_done(input string nm, input bit who,
                            input logic [63:0] r, input logic ovf);
        chk({nm, " done0"}, done0, !who);
        chk({nm, " done1"}, done1, who);
        chk({nm, " result"}, result, r);
        chk({nm, " ovf"}, overflow, ovf);
        chk({nm, " zf"}, zf, exp_zf(r));
        chk({nm, " sf"}, sf, exp_sf(r));
        chk({nm, " busy"}, busy, 1'b1);
    endtask

    // Single request from IDLE; operands are scrambled after the grant.
    task automatic run_op(input string nm, input vec_t v);
        @(negedge clk);
        if (!v.who) begin
            req0 = 1'b1; op0 = v.op; a0 = v.a; b0 = v.b;
        end else begin
            req1 = 1'b1; op1 = v.op; a1 = v.a; b1 = v.b;
        end
        @(negedge clk);
        chk({nm, " gnt0"}, gnt0, !v.who);
        chk({nm, " gnt1"}, gnt1, v.who);
        chk({nm, " done0 early"}, done0, 1'b0);
        chk({nm, " busy exec"}, busy, 1'b1);
        req0 = 1'b0; req1 = 1'b0;
        op0 = ~op0; op1 = ~op1;
        a0 = ~a0 + 64'd3; a1 = ~a1 + 64'd5;
        b0 = b0 ^ 64'h55; b1 = b1 ^ 64'haa;
        @(negedge clk);
        chk_done(nm, v.who, v.r, v.ovf);
        @(negedge clk);
        chk({nm, " busy idle"}, busy, 1'b0);
        chk({nm, " done idle"}, {62'd0, done0, done1}, 64'd0);
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
                   64'h8000_0000_0000_0000, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'd1,
                   64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 64'h1234, 64'h1234, 64'd0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 64'h8000_0000_0000_0000,
                   64'h8000_0000_0000_0000, 64'd0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 64'd0, 64'h8000_0000_0000_0000,
                   64'h8000_0000_0000_0000, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 64'd3, 64'd4, 64'd7, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst outs", {gnt0, gnt1, done0, done1, overflow, zf, sf, busy},
            64'd0);
        chk("rst result", result, 64'd0);
        rst_n = 1'b1;

        // Tie right after reset: 0, then 1, then 0 again.
        @(negedge clk);
        req0 = 1'b1; op0 = 1'b0; a0 = 64'd2; b0 = 64'd3;
        req1 = 1'b1; op1 = 1'b1; a1 = 64'd10; b1 = 64'd4;
        @(negedge clk);
        chk("tie g1 gnt0", gnt0, 1'b1);
        chk("tie g1 gnt1", gnt1, 1'b0);
        @(negedge clk);
        chk_done("tie d1", 1'b0, 64'd5, 1'b0);
        @(negedge clk);
        chk("tie g2 gnt1", gnt1, 1'b1);
        chk("tie g2 gnt0", gnt0, 1'b0);
        @(negedge clk);
        chk_done("tie d2", 1'b1, 64'd6, 1'b0);
        @(negedge clk);
        chk("tie g3 gnt0", gnt0, 1'b1);
        chk("tie g3 gnt1", gnt1, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk_done("tie d3", 1'b0, 64'd5, 1'b0);

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), tbl[i]);

        // Operand change during EXEC must not affect the captured op.
        @(negedge clk);
        req0 = 1'b1; op0 = 1'b0; a0 = 64'd10; b0 = 64'd20;
        @(negedge clk);
        chk("stab gnt0", gnt0, 1'b1);
        req0 = 1'b0; a0 = 64'd1000; op0 = 1'b1; b0 = 64'd5;
        @(negedge clk);
        chk_done("stab", 1'b0, 64'd30, 1'b0);

        // Reset during EXEC discards the op.
        @(negedge clk);
        req0 = 1'b1; op0 = 1'b0; a0 = 64'd100; b0 = 64'd1;
        @(negedge clk);
        chk("rmid gnt0", gnt0, 1'b1);
        req0 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rmid busy", busy, 1'b0);
        chk("rmid result", result, 64'd0);
        chk("rmid gnt0 clr", gnt0, 1'b0);
        @(negedge clk);
        chk("rmid done0", done0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rmid post done0", done0, 1'b0);
        chk("rmid post result", result, 64'd0);
        run_op("after rst", '{1'b0, 1'b0, 64'd40, 64'd2, 64'd42, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
